// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared definitions for the byte-serial carry look-ahead adder controller:
// FSM state encoding and the byte width of the shared adder slice.
package cla_seq_adder_ctrl_pkg;

  localparam int BYTE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Requester-side bundle for the sequential adder: start/operands in,
// busy/done handshake and full-width result with flags out.
interface cla_seq_adder_ctrl_if #(
  parameter int NBYTES = 4
);
  import cla_seq_adder_ctrl_pkg::*;

  localparam int W = BYTE * NBYTES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         zero;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, zero, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, zero, ovf
  );

endinterface

// File: rtl/cla_seq_adder_ctrl_cla8.sv
// 8-bit carry look-ahead adder. Each carry is formed directly as a
// sum of generate/propagate products rather than rippling bit to bit.
module Carry_Look_Ahead_Adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] s,
  output logic       c8
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       prod;

  // Expand c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0 for every bit
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    prod = 1'b1;
    c[0] = c0;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & c0);
    end
    s  = p ^ c[7:0];
    c8 = c[8];
  end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-byte adder that time-multiplexes one 8-bit CLA slice, LSB first,
// threading each byte's carry-out into the next byte's carry-in.
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_seq_adder_ctrl_if.slave   bus
);

  localparam int W    = BYTE * NBYTES;
  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t          state_q;
  state_t          state_d;
  logic            accept;
  logic            last_add;

  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [W-1:0]    sum_d;
  logic            carry_q;
  logic            busy_q;
  logic            done_q;
  logic            cout_q;
  logic            zero_q;
  logic            ovf_q;

  logic [BYTE-1:0] add_a;
  logic [BYTE-1:0] add_b;
  logic [BYTE-1:0] add_s;
  logic            add_c8;

  Carry_Look_Ahead_Adder_8bit u_cla (
    .a  (add_a),
    .b  (add_b),
    .c0 (carry_q),
    .s  (add_s),
    .c8 (add_c8)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode: accept start only in IDLE, leave ADD after the top byte
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_add = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        if (idx_q == LAST_IDX) begin
          last_add = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the current byte slice and merge the adder result into the sum
  always_comb begin
    add_a = a_q[BYTE*idx_q +: BYTE];
    add_b = b_q[BYTE*idx_q +: BYTE];
    sum_d = sum_q;
    sum_d[BYTE*idx_q +: BYTE] = add_s;
  end

  // Operand latching, byte-by-byte accumulation, flags and registered handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        carry_q <= bus.cin;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (state_q == ADD) begin
        sum_q   <= sum_d;
        carry_q <= add_c8;
        idx_q   <= last_add ? '0 : idx_q + 1'b1;
        if (last_add) begin
          cout_q <= add_c8;
          zero_q <= (sum_d == '0);
          ovf_q  <= (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule
